// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: accelerator FSM
// state encodings and the default accelerator timeout.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } acc_state_e;

    localparam int unsigned ACC_TIMEOUT_DEFAULT = 1024;

    function automatic logic acc_is_busy(acc_state_e s);
        return (s == ST_ISSUE) || (s == ST_WAIT);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Start/ready/done handshake between the hazard controller and the accelerator.
interface pipe_hazard_ctrl_if;
    logic acc_start;
    logic acc_ready;
    logic acc_done;

    modport master (output acc_start, input acc_ready, input acc_done);
    modport slave  (input acc_start, output acc_ready, output acc_done);
endinterface

// File: rtl/pipe_hazard_ctrl_acc_seq_fsm.sv
// Accelerator sequencing FSM with wait counter, sticky timeout flag and a
// saturating busy-cycle counter; acc_start/acc_busy are registered.
module acc_seq_fsm
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned ACC_TIMEOUT = ACC_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_req,
    input  logic        acc_ready,
    input  logic        acc_done,
    output acc_state_e  state,
    output logic        acc_start,
    output logic        acc_busy,
    output logic        acc_timeout,
    output logic [31:0] acc_cycles
);

    localparam logic [15:0] WAIT_LAST = 16'(ACC_TIMEOUT - 1);

    logic [15:0] wait_cnt;

    // NOTE: every register here uses <= so all updates see the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            acc_start   <= 1'b0;
            acc_busy    <= 1'b0;
            acc_timeout <= 1'b0;
            acc_cycles  <= '0;
        end else begin
            if (acc_is_busy(state) && (acc_cycles != '1))
                acc_cycles <= acc_cycles + 32'd1;

            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state     <= ST_ISSUE;
                        acc_start <= 1'b1;
                        acc_busy  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (acc_ready) begin
                        acc_start <= 1'b0;
                        if (acc_done) begin
                            state    <= ST_DONE;
                            acc_busy <= 1'b0;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + 16'd1;
                    if (acc_done || (wait_cnt == WAIT_LAST)) begin
                        state    <= ST_DONE;
                        acc_busy <= 1'b0;
                        // a real completion on the last cycle is not a timeout
                        if (!acc_done)
                            acc_timeout <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush and accelerator
// stall, with the accelerator sequencing delegated to acc_seq_fsm.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned ACC_TIMEOUT = ACC_TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             rs1_id,
    input  logic [4:0]             rs2_id,
    input  logic                   rs1_used_id,
    input  logic                   rs2_used_id,
    input  logic [4:0]             rd_ex,
    input  logic                   mem_read_ex,
    input  logic                   redirect_ex,
    input  logic                   accelerator_instr_ex,
    pipe_hazard_ctrl_if.master     acc_if,
    output logic                   stall_if,
    output logic                   stall_id,
    output logic                   stall_ex,
    output logic                   bubble_id,
    output logic                   bubble_ex,
    output logic                   bubble_mem,
    output logic                   acc_busy,
    output logic                   acc_timeout,
    output logic [31:0]            acc_cycles
);

    acc_state_e state;
    logic       start_req;
    logic       acc_stall;
    logic       load_use;
    logic       lu_stall;

    // an illegal redirect+accelerator combination flushes and never starts the FSM
    assign start_req = accelerator_instr_ex && !redirect_ex;

    acc_seq_fsm #(.ACC_TIMEOUT(ACC_TIMEOUT)) u_fsm (
        .clk         (clk),
        .rst         (rst),
        .start_req   (start_req),
        .acc_ready   (acc_if.acc_ready),
        .acc_done    (acc_if.acc_done),
        .state       (state),
        .acc_start   (acc_if.acc_start),
        .acc_busy    (acc_busy),
        .acc_timeout (acc_timeout),
        .acc_cycles  (acc_cycles)
    );

    assign acc_stall = ((state == ST_IDLE) && start_req) || acc_is_busy(state);

    assign load_use = mem_read_ex && (rd_ex != 5'd0) &&
                      ((rs1_used_id && (rs1_id == rd_ex)) ||
                       (rs2_used_id && (rs2_id == rd_ex)));

    // accelerator stall and redirect both override the load-use interlock
    assign lu_stall = load_use && !acc_stall && !redirect_ex;

    assign stall_if   = !rst && (acc_stall || lu_stall);
    assign stall_id   = !rst && (acc_stall || lu_stall);
    assign stall_ex   = !rst && acc_stall;
    assign bubble_id  = !rst && redirect_ex;
    assign bubble_ex  = !rst && (redirect_ex || lu_stall);
    assign bubble_mem = !rst && acc_stall;

endmodule
